// File: rtl/port_alloc.sv
// Two-stage oldest-first port allocator for a 4-input deflection router.
// Macro PORT_ALLOC_OLDEST_FIRST_EN enables age-based ranking; otherwise fixed priority (input 0 first).
module port_alloc #(
    parameter int AGE_W  = 8,
    parameter int NUM_IN = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN-1:0]         in_valid,
    input  logic [NUM_IN*AGE_W-1:0]   in_age,
    input  logic [NUM_IN*5-1:0]       in_prod,
    input  logic                      defl_clr,
    output logic [NUM_IN-1:0]         out_valid,
    output logic [NUM_IN*5-1:0]       out_alloc,
    output logic [NUM_IN-1:0]         out_defl,
    output logic [15:0]               defl_cnt
);

    localparam int RANK_W = $clog2(NUM_IN);

    // An all-zero age mask makes every age tie, so ranking falls back to input index.
`ifdef PORT_ALLOC_OLDEST_FIRST_EN
    localparam logic [AGE_W-1:0] AGE_MASK = {AGE_W{1'b1}};
`else
    localparam logic [AGE_W-1:0] AGE_MASK = {AGE_W{1'b0}};
`endif

    logic [NUM_IN-1:0]       r_valid;
    logic [NUM_IN*AGE_W-1:0] r_age;
    logic [NUM_IN*5-1:0]     r_prod;

    logic [NUM_IN-1:0]       r_out_valid;
    logic [NUM_IN*5-1:0]     r_out_alloc;
    logic [NUM_IN-1:0]       r_out_defl;
    logic [15:0]             r_defl_cnt;

    logic [RANK_W-1:0]       w_rank [NUM_IN];
    logic [NUM_IN*5-1:0]     w_alloc;
    logic [NUM_IN-1:0]       w_defl;
    logic [2:0]              w_defl_pop;
    logic [16:0]             w_cnt_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_age   <= '0;
            r_prod  <= '0;
        end else begin
            r_valid <= in_valid;
            r_age   <= in_age;
            r_prod  <= in_prod;
        end
    end

    // Rank = number of valid flits that beat this one (older, or same age and lower index).
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            w_rank[i] = '0;
            for (int j = 0; j < NUM_IN; j++) begin
                if (j != i && r_valid[j]) begin
                    if (((r_age[j*AGE_W +: AGE_W] & AGE_MASK) > (r_age[i*AGE_W +: AGE_W] & AGE_MASK)) ||
                        (((r_age[j*AGE_W +: AGE_W] & AGE_MASK) == (r_age[i*AGE_W +: AGE_W] & AGE_MASK)) && (j < i))) begin
                        w_rank[i] = w_rank[i] + RANK_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin : alloc
        logic [4:0] v_free;
        logic [4:0] v_cand;
        logic [4:0] v_gnt;
        w_alloc = '0;
        w_defl  = '0;
        v_free  = 5'b11111;
        v_cand  = '0;
        v_gnt   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (r_valid[i] && (w_rank[i] == RANK_W'(k))) begin
                    v_cand = r_prod[i*5 +: 5] & v_free;
                    if (v_cand != 5'b0) begin
                        v_gnt = v_cand & (~v_cand + 5'd1);
                    end else begin
                        // At most 3 earlier flits, so a network port is always left.
                        v_cand    = v_free & 5'b11110;
                        v_gnt     = v_cand & (~v_cand + 5'd1);
                        w_defl[i] = 1'b1;
                    end
                    w_alloc[i*5 +: 5] = v_gnt;
                    v_free = v_free & ~v_gnt;
                end
            end
        end
    end

    always_comb begin
        w_defl_pop = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_defl_pop = w_defl_pop + {2'b00, w_defl[i]};
        end
        w_cnt_sum = {1'b0, r_defl_cnt} + {14'd0, w_defl_pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= '0;
            r_out_alloc <= '0;
            r_out_defl  <= '0;
            r_defl_cnt  <= '0;
        end else begin
            r_out_valid <= r_valid;
            r_out_alloc <= w_alloc;
            r_out_defl  <= w_defl;
            if (defl_clr) begin
                r_defl_cnt <= '0;
            end else if (w_cnt_sum[16]) begin
                r_defl_cnt <= 16'hFFFF;
            end else begin
                r_defl_cnt <= w_cnt_sum[15:0];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_alloc = r_out_alloc;
    assign out_defl  = r_out_defl;
    assign defl_cnt  = r_defl_cnt;

endmodule
